// File: rtl/dma_target_mem_pkg.sv
// Shared types and constants for the DELQA DMA target memory model.
package dma_target_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWNED,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE,
    ST_NXM
  } state_t;

  localparam logic [21:0] DEF_MEM_BASE = 22'o0100000;

  // Bus cycle captured on the strobe; replayed at the access edge.
  typedef struct packed {
    logic        we;
    logic [15:0] dat;
  } dma_cyc_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dma_target_ram.sv
// Word memory behind the bus target: synchronous write, read data
// presented combinationally and captured by the caller's output registers.
module dma_target_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [15:0]   wdat,
  output logic [15:0]   rdat
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clk_i)
    if (we) mem[adr] <= wdat;

  assign rdat = mem[adr];

endmodule

// File: rtl/dma_target_mem.sv
// Q-bus style DMA responder: grants the bus, acks each strobe after wait
// states, and never acks outside the window so the master times out (nxm).
module dma_target_mem
  import dma_target_mem_pkg::*;
#(
  parameter logic [21:0] MEM_BASE    = DEF_MEM_BASE,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 2,
  localparam int         AW          = clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          bus_busy,
  input  logic          dma_req,
  output logic          dma_gnt,
  input  logic [21:0]   dma_adr_i,
  input  logic [15:0]   dma_dat_i,
  output logic [15:0]   dma_dat_o,
  input  logic          dma_stb_i,
  input  logic          dma_we_i,
  output logic          dma_ack_o,
  output logic          nxm_o,
  input  logic          hst_en,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_adr,
  input  logic [15:0]   hst_dat_i,
  output logic [15:0]   hst_dat_o,
  output logic          hst_ack
);

  localparam logic [21:0] BASE_W = {1'b0, MEM_BASE[21:1]};
  localparam logic [21:0] TOP_W  = BASE_W + 22'(MEM_WORDS);

  state_t        state;
  logic [3:0]    cnt;
  dma_cyc_t      cyc;
  logic [AW-1:0] idx_q;

  logic [21:0]   adr_w;
  logic          in_win;
  logic [AW-1:0] idx_w;
  logic          unused_adr0;

  assign adr_w       = {1'b0, dma_adr_i[21:1]};
  assign in_win      = (adr_w >= BASE_W) && (adr_w < TOP_W);
  assign idx_w       = AW'(adr_w - BASE_W);
  assign unused_adr0 = dma_adr_i[0];

  // Host owns the RAM port only while idle; otherwise the latched DMA cycle does.
  logic          host_sel, dma_go;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [15:0]   ram_wdat, ram_rdat;

  assign host_sel = (state == ST_IDLE);
  assign dma_go   = (state == ST_WAIT) && dma_req && (cnt == 4'd0);

  always_comb begin
    ram_adr  = host_sel ? hst_adr   : idx_q;
    ram_wdat = host_sel ? hst_dat_i : cyc.dat;
    ram_we   = host_sel ? (hst_en & hst_we) : (dma_go & cyc.we);
  end

  dma_target_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .adr   (ram_adr),
    .wdat  (ram_wdat),
    .rdat  (ram_rdat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cyc       <= '0;
      idx_q     <= '0;
      dma_gnt   <= 1'b0;
      dma_ack_o <= 1'b0;
      nxm_o     <= 1'b0;
      hst_ack   <= 1'b0;
      dma_dat_o <= 16'd0;
      hst_dat_o <= 16'd0;
    end else begin
      dma_ack_o <= 1'b0;
      nxm_o     <= 1'b0;
      hst_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hst_en) begin
            hst_ack <= 1'b1;
            if (!hst_we) hst_dat_o <= ram_rdat;
          end else if (dma_req && !bus_busy) begin
            dma_gnt <= 1'b1;
            state   <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!dma_req) begin
            dma_gnt <= 1'b0;
            state   <= ST_IDLE;
          end else if (dma_stb_i) begin
            cyc   <= '{we: dma_we_i, dat: dma_dat_i};
            idx_q <= idx_w;
            if (in_win) begin
              cnt   <= 4'(WAIT_STATES);
              state <= ST_WAIT;
            end else begin
              nxm_o <= 1'b1;
              state <= ST_NXM;
            end
          end
        end
        ST_WAIT: begin
          if (!dma_req) begin
            dma_gnt <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            dma_ack_o <= 1'b1;
            if (!cyc.we) dma_dat_o <= ram_rdat;
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (!dma_req) begin
            dma_gnt <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            state <= ST_RELEASE;
          end
        end
        // A strobe held past its ack (or past nxm) must drop before the next cycle.
        ST_RELEASE, ST_NXM: begin
          if (!dma_req) begin
            dma_gnt <= 1'b0;
            state   <= ST_IDLE;
          end else if (!dma_stb_i) begin
            state <= ST_OWNED;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_target_mem.sv
// Directed bench for dma_target_mem: transaction-level model of expected
// grant/ack/nxm/host timing and memory contents, checked every cycle.
module tb_dma_target_mem;

  localparam int WS = 2;
  localparam int MW = 1024;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          bus_busy = 1'b0;
  logic          dma_req = 1'b0;
  logic          dma_gnt;
  logic [21:0]   dma_adr_i = '0;
  logic [15:0]   dma_dat_i = '0;
  logic [15:0]   dma_dat_o;
  logic          dma_stb_i = 1'b0;
  logic          dma_we_i = 1'b0;
  logic          dma_ack_o;
  logic          nxm_o;
  logic          hst_en = 1'b0;
  logic          hst_we = 1'b0;
  logic [AW-1:0] hst_adr = '0;
  logic [15:0]   hst_dat_i = '0;
  logic [15:0]   hst_dat_o;
  logic          hst_ack;

  always #5 clk_i = ~clk_i;

  dma_target_mem #(.MEM_BASE(22'o0100000), .MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus_busy  (bus_busy),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .dma_adr_i (dma_adr_i),
    .dma_dat_i (dma_dat_i),
    .dma_dat_o (dma_dat_o),
    .dma_stb_i (dma_stb_i),
    .dma_we_i  (dma_we_i),
    .dma_ack_o (dma_ack_o),
    .nxm_o     (nxm_o),
    .hst_en    (hst_en),
    .hst_we    (hst_we),
    .hst_adr   (hst_adr),
    .hst_dat_i (hst_dat_i),
    .hst_dat_o (hst_dat_o),
    .hst_ack   (hst_ack)
  );

  // Model: memory image plus the cycle numbers at which each pulse is due.
  logic [15:0] mem_m [MW];
  int          cyc_n = 0;
  int          ack_at = -1, nxm_at = -1, hst_at = -1;
  int          gnt_from = 1 << 30, gnt_to = 0;
  logic        ack_rd = 1'b0, hst_rd = 1'b0;
  logic [15:0] ack_val = '0, hst_val = '0;
  logic [15:0] exp_dat = '0, exp_hdat = '0;
  bit          chk_en = 1'b0;
  int          checks = 0, failures = 0;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_dat  = '0;
      exp_hdat = '0;
    end else if (chk_en) begin
      if (cyc_n == ack_at && ack_rd) exp_dat = ack_val;
      if (cyc_n == hst_at && hst_rd) exp_hdat = hst_val;
      chk("gnt", dma_gnt, (cyc_n >= gnt_from) && (cyc_n < gnt_to));
      chk("ack", dma_ack_o, cyc_n == ack_at);
      chk("nxm", nxm_o, cyc_n == nxm_at);
      chk("hst_ack", hst_ack, cyc_n == hst_at);
      chk("dma_dat_o", dma_dat_o, exp_dat);
      chk("hst_dat_o", hst_dat_o, exp_hdat);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic grant();
    dma_req = 1'b1; gnt_from = cyc_n + 1; gnt_to = 1 << 30;
    step(2);
  endtask

  task automatic drop_req();
    dma_req = 1'b0; gnt_to = cyc_n + 1;
    step(2);
  endtask

  task automatic host(input bit we, input int adr, input logic [15:0] d);
    hst_en = 1'b1; hst_we = we; hst_adr = AW'(adr); hst_dat_i = d;
    hst_at = cyc_n + 1; hst_rd = !we;
    if (we) mem_m[adr] = d; else hst_val = mem_m[adr];
    step(1);
    hst_en = 1'b0; hst_we = 1'b0;
    step(1);
  endtask

  // One master bus cycle; lat = cycles from strobe sample to ack, -1 if none.
  task automatic dma_rw(input bit we, input logic [21:0] adr, input logic [15:0] d, output int lat);
    int  idx, k;
    bit  seen;
    idx = (int'(adr) - 32768) / 2;
    dma_stb_i = 1'b1; dma_we_i = we; dma_adr_i = adr; dma_dat_i = d;
    k = cyc_n + 1;
    ack_at = k + 1 + WS; ack_rd = !we;
    if (we) mem_m[idx] = d; else ack_val = mem_m[idx];
    seen = 1'b0; lat = -1;
    for (int i = 0; i < 64 && !seen; i++) begin
      step(1);
      seen = dma_ack_o;
    end
    chk("ack_seen", seen, 1'b1);
    if (seen) lat = cyc_n - k;
    dma_stb_i = 1'b0; dma_we_i = 1'b0;
    step(2);
  endtask

  initial begin
    int lat, n, acks;
    step(2);
    chk("rst_outs", {dma_gnt, dma_ack_o, nxm_o, hst_ack, dma_dat_o, hst_dat_o}, 64'd0);
    rst_i = 1'b0;
    step(1);
    chk_en = 1'b1;

    // grant and release
    grant();
    chk("gnt_on", dma_gnt, 1'b1);
    drop_req();
    chk("gnt_off", dma_gnt, 1'b0);

    // write then read word 4, check latency and host view
    grant();
    dma_rw(1'b1, 22'o0100010, 16'o123456, lat);
    chk("wr_latency", lat, 3);
    dma_rw(1'b0, 22'o0100010, 16'o0, lat);
    chk("rd_latency", lat, 3);
    chk("rd_data", dma_dat_o, 16'o123456);
    drop_req();
    host(1'b0, 4, 16'o0);
    chk("hst_rd4", hst_dat_o, 16'o123456);

    // out-of-window strobe held 64 cycles
    grant();
    dma_stb_i = 1'b1; dma_we_i = 1'b0; dma_adr_i = 22'o0000000;
    nxm_at = cyc_n + 1;
    n = 0; acks = 0;
    repeat (64) begin
      step(1);
      if (nxm_o) n++;
      if (dma_ack_o) acks++;
    end
    chk("nxm_pulses", n, 1);
    chk("nxm_no_ack", acks, 0);
    dma_stb_i = 1'b0;
    step(2);
    dma_rw(1'b0, 22'o0100010, 16'o0, lat);
    chk("post_nxm_rd", dma_dat_o, 16'o123456);

    // 8-word burst from the window base
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      dma_rw(1'b1, 22'o0100000 + 22'(2 * i), 16'o070000 + 16'(i * 'o111), lat);
      if (lat >= 0) acks++;
    end
    chk("burst_acks", acks, 8);
    drop_req();
    for (int i = 0; i < 8; i++) host(1'b0, i, 16'o0);
    chk("burst_w7", hst_dat_o, 16'o070777);

    // abort a write in its wait states
    grant();
    dma_stb_i = 1'b1; dma_we_i = 1'b1; dma_adr_i = 22'o0100012; dma_dat_i = 16'o177777;
    step(1);
    dma_req = 1'b0; gnt_to = cyc_n + 1;
    step(1);
    dma_stb_i = 1'b0; dma_we_i = 1'b0;
    step(2);
    chk("abort_gnt", dma_gnt, 1'b0);
    host(1'b0, 5, 16'o0);
    chk("abort_word5", hst_dat_o, 16'o070555);

    // bus_busy blocks grant; host held off while granted
    bus_busy = 1'b1; dma_req = 1'b1;
    step(5);
    chk("busy_no_gnt", dma_gnt, 1'b0);
    dma_req = 1'b0; bus_busy = 1'b0;
    step(1);
    grant();
    hst_en = 1'b1; hst_we = 1'b0; hst_adr = AW'(4);
    step(5);
    chk("hst_held", hst_ack, 1'b0);
    dma_req = 1'b0; gnt_to = cyc_n + 1;
    hst_at = cyc_n + 2; hst_rd = 1'b1; hst_val = mem_m[4];
    step(2);
    chk("hst_after_gnt", hst_ack, 1'b1);
    hst_en = 1'b0;
    step(2);

    // reset asserted while ack is high
    grant();
    dma_stb_i = 1'b1; dma_we_i = 1'b0; dma_adr_i = 22'o0100010;
    ack_at = cyc_n + 2 + WS; ack_rd = 1'b1; ack_val = mem_m[4];
    for (int i = 0; i < 16 && !dma_ack_o; i++) step(1);
    chk("pre_rst_ack", dma_ack_o, 1'b1);
    #1 rst_i = 1'b1;
    #1 chk("async_rst", {dma_gnt, dma_ack_o, nxm_o, hst_ack, dma_dat_o, hst_dat_o}, 64'd0);
    dma_req = 1'b0; dma_stb_i = 1'b0;
    gnt_from = 1 << 30; gnt_to = 0; ack_at = -1;
    step(2);
    rst_i = 1'b0;
    step(2);
    grant();
    drop_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
